// File: rtl/clks_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clks_pkg
// Description : Shared constants and types for the clock-divider tree.
// Revision    : 1.0 - initial release
// ============================================================================
package clks_pkg;

    localparam int DEF_N_OUT    = 3;
    localparam int DEF_DIV_W    = 4;
    localparam int DEF_HALF_DIV = 5;

    // Half-period divider value at the default divider width
    typedef logic [DEF_DIV_W-1:0] half_div_t;

endpackage : clks_pkg
`default_nettype wire

// File: rtl/clk_div_tick.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_tick
// Description : Half-period counter. Emits a tick every hd enabled cycles
//               and accepts a new half-divider through a load port.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_tick
    import clks_pkg::*;
#(
    parameter int DIV_W  = DEF_DIV_W,
    parameter int RST_HD = DEF_HALF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enb,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_load_val,
    output logic             o_tick
);

    localparam logic [DIV_W-1:0] c_one     = DIV_W'(1);
    localparam logic [DIV_W-1:0] c_rst_hd  = DIV_W'(RST_HD);
    // Starting one short of the terminal count makes the first enabled cycle tick
    localparam logic [DIV_W-1:0] c_rst_cnt = DIV_W'(RST_HD - 1);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_hd;
    logic [DIV_W-1:0] w_load_hd;

    // A requested half-period of zero is clamped to one
    assign w_load_hd = (i_load_val == '0) ? c_one : i_load_val;

    assign o_tick = i_enb && (r_cnt >= (r_hd - c_one));

    // Counter and active half-divider; a load restarts the half-period at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hd  <= c_rst_hd;
            r_cnt <= c_rst_cnt;
        end else if (i_load) begin
            r_hd  <= w_load_hd;
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else if (i_enb) begin
            r_cnt <= r_cnt + c_one;
        end
    end

endmodule : clk_div_tick
`default_nettype wire

// File: rtl/clk_div_tree.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_tree
// Description : Clock-divider tree producing N_OUT phase-aligned divided
//               clocks, each half the frequency of the previous, with a
//               runtime-programmable base divider, change handshake and lock.
//               Optional per-output edge strobes under macro
//               CLK_DIV_TREE_STROBE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_tree
    import clks_pkg::*;
#(
    parameter int N_OUT        = DEF_N_OUT,
    parameter int DIV_W        = DEF_DIV_W,
    parameter int DEF_HALF_DIV = clks_pkg::DEF_HALF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic [DIV_W-1:0] half_div,
    input  logic             div_req,
    output logic             div_ack,
    output logic [N_OUT-1:0] clk_out,
    output logic             locked
`ifdef CLK_DIV_TREE_STROBE_EN
    ,
    output logic [N_OUT-1:0] rise_stb,
    output logic [N_OUT-1:0] fall_stb
`endif
);

    localparam logic [N_OUT-1:0] c_phase_one = N_OUT'(1);

    logic             w_tick;
    logic             w_boundary;
    logic             w_accept;
    logic [N_OUT-1:0] w_phase_nxt;

    logic [N_OUT-1:0] r_phase;
    logic             r_started;
    logic             r_locked;
    logic             r_accept;
    logic             r_div_ack;

    clk_div_tick #(
        .DIV_W  (DIV_W),
        .RST_HD (DEF_HALF_DIV)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .i_enb      (enb),
        .i_load     (w_accept),
        .i_load_val (half_div),
        .o_tick     (w_tick)
    );

    // Down-counting phase: bit k toggles whenever all lower bits are zero,
    // and every output rises together on the wrap from 0 to all-ones
    assign w_phase_nxt = r_phase - c_phase_one;
    assign w_boundary  = w_tick && (r_phase == '0);
    assign w_accept    = w_boundary && div_req;

    // Phase register; it directly drives the divided clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
        end else if (w_tick) begin
            r_phase <= w_phase_nxt;
        end
    end

    // Lock tracking and ratio-change handshake; ack lags acceptance by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_started <= 1'b0;
            r_locked  <= 1'b0;
            r_accept  <= 1'b0;
            r_div_ack <= 1'b0;
        end else begin
            r_accept  <= w_accept;
            r_div_ack <= r_accept;
            if (w_accept) begin
                r_started <= 1'b0;
                r_locked  <= 1'b0;
            end else begin
                if (w_tick) begin
                    r_started <= 1'b1;
                end
                if (w_boundary && r_started) begin
                    r_locked <= 1'b1;
                end
            end
        end
    end

    assign clk_out = r_phase;
    assign locked  = r_locked;
    assign div_ack = r_div_ack;

`ifdef CLK_DIV_TREE_STROBE_EN
    logic [N_OUT-1:0] r_rise;
    logic [N_OUT-1:0] r_fall;

    // Edge strobes registered with the phase so they align with clk_out changes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rise <= '0;
            r_fall <= '0;
        end else if (w_tick) begin
            r_rise <= ~r_phase & w_phase_nxt;
            r_fall <= r_phase & ~w_phase_nxt;
        end else begin
            r_rise <= '0;
            r_fall <= '0;
        end
    end

    assign rise_stb = r_rise;
    assign fall_stb = r_fall;
`else
    // Strobes are not built in this configuration
`endif

endmodule : clk_div_tree
`default_nettype wire

// File: tb/tb_clk_div_tree.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_tree
// Description : Self-checking bench for clk_div_tree: directed vector table,
//               reset-with-pending-request sequence and randomized traffic
//               checked against a position-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_tree;
    import clks_pkg::*;

    localparam int NP = 8;   // 2**N_OUT for N_OUT = 3

    logic       clk;
    logic       rst;
    logic       enb;
    half_div_t  half_div;
    logic       div_req;
    logic       div_ack;
    logic [2:0] clk_out;
    logic       locked;
`ifdef CLK_DIV_TREE_STROBE_EN
    logic [2:0] rise_stb;
    logic [2:0] fall_stb;
`endif

    int n_chk = 0;
    int n_err = 0;

    clk_div_tree #(
        .N_OUT        (3),
        .DIV_W        (4),
        .DEF_HALF_DIV (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .half_div (half_div),
        .div_req  (div_req),
        .div_ack  (div_ack),
        .clk_out  (clk_out),
        .locked   (locked)
`ifdef CLK_DIV_TREE_STROBE_EN
        ,
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position within the current epoch (an epoch starts at
    // the first tick after reset or at an accepted ratio change)
    int         m_hd;
    int         m_t;
    bit         m_pre;
    bit         m_lock;
    bit         m_accd;
    bit         m_ack;
    logic [2:0] m_out;
    logic [2:0] m_rise;
    logic [2:0] m_fall;

    task automatic model_edge();
        logic [2:0] prev;
        bit         bnd;
        if (rst) begin
            m_hd = 5; m_t = 0; m_pre = 1; m_lock = 0;
            m_accd = 0; m_ack = 0; m_out = '0; m_rise = '0; m_fall = '0;
        end else begin
            prev   = m_out;
            m_ack  = m_accd;
            m_accd = 0;
            if (enb) begin
                bnd = m_pre || (m_t + 1 == m_hd * NP);
                if (bnd) begin
                    if (div_req) begin
                        m_hd   = (half_div == 0) ? 1 : int'(half_div);
                        m_accd = 1;
                        m_lock = 0;
                    end else if (!m_pre) begin
                        m_lock = 1;
                    end
                    m_t   = 0;
                    m_pre = 0;
                end else begin
                    m_t = m_t + 1;
                end
                m_out = 3'(7 - ((m_t / m_hd) % NP));
            end
            m_rise = m_out & ~prev;
            m_fall = ~m_out & prev;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: model sees the same inputs as the DUT edge, compare 1 ns later
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_clk_out", clk_out, m_out);
        chk("model_locked", locked, m_lock);
        chk("model_div_ack", div_ack, m_ack);
`ifdef CLK_DIV_TREE_STROBE_EN
        chk("model_rise_stb", rise_stb, m_rise);
        chk("model_fall_stb", fall_stb, m_fall);
`endif
    endtask

    task automatic do_reset();
        rst = 1; enb = 1; div_req = 0; half_div = 5;
        cyc();
        cyc();
        chk("reset_clk_out", clk_out, 0);
        chk("reset_locked", locked, 0);
        chk("reset_div_ack", div_ack, 0);
        rst = 0;
    endtask

    typedef struct {
        int         run;
        int         cyc;
        bit         enb;
        bit         req;
        half_div_t  hdv;
        logic [2:0] e_clk;
        bit         e_lk;
        bit         e_ack;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int r, int c, bit e, bit q, int h, int ec, bit el, bit ea);
        vec_t v;
        v.run = r; v.cyc = c; v.enb = e; v.req = q; v.hdv = half_div_t'(h);
        v.e_clk = 3'(ec); v.e_lk = el; v.e_ack = ea;
        tbl.push_back(v);
    endfunction

    initial begin
        int  run_len[4];
        int  p;
        bit  any_ack;

        rst = 1; enb = 0; div_req = 0; half_div = 5;

        // run 0: free-running at the reset ratio
        add(0,  1, 1, 0, 5, 7, 0, 0);
        add(0,  5, 1, 0, 5, 7, 0, 0);
        add(0,  6, 1, 0, 5, 6, 0, 0);
        add(0, 11, 1, 0, 5, 5, 0, 0);
        add(0, 16, 1, 0, 5, 4, 0, 0);
        add(0, 21, 1, 0, 5, 3, 0, 0);
        add(0, 26, 1, 0, 5, 2, 0, 0);
        add(0, 31, 1, 0, 5, 1, 0, 0);
        add(0, 36, 1, 0, 5, 0, 0, 0);
        add(0, 40, 1, 0, 5, 0, 0, 0);
        add(0, 41, 1, 0, 5, 7, 1, 0);
        add(0, 46, 1, 0, 5, 6, 1, 0);
        // run 1: request half_div=2 at cycle 13, adopted at the boundary at 41
        add(1,  1, 1, 0, 5, 7, 0, 0);
        add(1, 12, 1, 0, 5, 5, 0, 0);
        add(1, 13, 1, 1, 2, 5, 0, 0);
        add(1, 40, 1, 1, 2, 0, 0, 0);
        add(1, 41, 1, 1, 2, 7, 0, 0);
        add(1, 42, 1, 1, 2, 7, 0, 1);
        add(1, 43, 1, 0, 2, 6, 0, 0);
        add(1, 45, 1, 0, 2, 5, 0, 0);
        add(1, 55, 1, 0, 2, 0, 0, 0);
        add(1, 56, 1, 0, 2, 0, 0, 0);
        add(1, 57, 1, 0, 2, 7, 1, 0);
        // run 2: half_div=0 adopted as 1 on the very first tick
        add(2,  1, 1, 1, 0, 7, 0, 0);
        add(2,  2, 1, 1, 0, 6, 0, 1);
        add(2,  3, 1, 0, 0, 5, 0, 0);
        add(2,  5, 1, 0, 0, 3, 0, 0);
        add(2,  8, 1, 0, 0, 0, 0, 0);
        add(2,  9, 1, 0, 0, 7, 1, 0);
        add(2, 10, 1, 0, 0, 6, 1, 0);
        // run 3: enable low for cycles 9..15, period resumes where it stopped
        add(3,  1, 1, 0, 5, 7, 0, 0);
        add(3,  8, 1, 0, 5, 6, 0, 0);
        add(3,  9, 0, 0, 5, 6, 0, 0);
        add(3, 15, 0, 0, 5, 6, 0, 0);
        add(3, 16, 1, 0, 5, 6, 0, 0);
        add(3, 17, 1, 0, 5, 6, 0, 0);
        add(3, 18, 1, 0, 5, 5, 0, 0);

        run_len = '{46, 57, 10, 18};
        p = 0;

        for (int r = 0; r < 4; r++) begin
            do_reset();
            enb = 1; div_req = 0; half_div = 5;
            for (int c = 1; c <= run_len[r]; c++) begin
                bit hit;
                hit = (p < tbl.size()) && (tbl[p].run == r) && (tbl[p].cyc == c);
                if (hit) begin
                    enb      = tbl[p].enb;
                    div_req  = tbl[p].req;
                    half_div = tbl[p].hdv;
                end
                cyc();
                if (hit) begin
                    chk($sformatf("vec_clk_out r%0d c%0d", r, c), clk_out, tbl[p].e_clk);
                    chk($sformatf("vec_locked r%0d c%0d", r, c), locked, tbl[p].e_lk);
                    chk($sformatf("vec_div_ack r%0d c%0d", r, c), div_ack, tbl[p].e_ack);
                    p++;
                end
`ifdef CLK_DIV_TREE_STROBE_EN
                if (r == 0 && c == 1) chk("rise_stb_c1", rise_stb, 3'b111);
                if (r == 0 && c == 2) chk("rise_stb_c2", rise_stb, 3'b000);
                if (r == 0 && c == 6) chk("fall_stb_c6", fall_stb, 3'b001);
                if (r == 3 && c >= 9 && c <= 15) chk("stb_frozen", {rise_stb, fall_stb}, 6'b0);
`endif
            end
        end

        // Reset lands between acceptance and acknowledge: no ack, reset ratio
        do_reset();
        enb = 1; div_req = 0;
        for (int c = 1; c <= 39; c++) cyc();
        div_req = 1; half_div = 3;
        cyc();
        cyc();
        rst = 1;
        cyc();
        chk("rst_pending_ack", div_ack, 0);
        chk("rst_pending_clk", clk_out, 0);
        chk("rst_pending_lock", locked, 0);
        cyc();
        rst = 0; div_req = 0; half_div = 5;
        any_ack = 0;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (div_ack) any_ack = 1;
            if (c == 5) chk("rst_hd_c5", clk_out, 3'b111);
            if (c == 6) chk("rst_hd_c6", clk_out, 3'b110);
        end
        chk("rst_dropped_ack", any_ack, 0);

        // Randomized traffic against the model
        div_req = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            enb = ($urandom_range(0, 7) != 0);
            if (!div_req && $urandom_range(0, 24) == 0) begin
                div_req  = 1;
                half_div = half_div_t'($urandom_range(0, 15));
            end
            cyc();
            if (div_ack) div_req = 0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_clk_div_tree
`default_nettype wire
